// File: rtl/cache_refill_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cache_refill_ctrl_if
//  Description : Bundles the cache-side miss/fill handshake and the
//                word-wide memory port of the refill controller.
//                master = refill controller, slave = cache + memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cache_refill_ctrl_if #(
    parameter int TAG_W = 26
);
    localparam int c_ADDR_W = TAG_W + 6;

    // cache -> controller miss request
    logic                miss_req;
    logic [TAG_W-1:0]    miss_tag;
    logic [1:0]          miss_index;
    logic                victim_dirty;
    logic [TAG_W-1:0]    victim_tag;
    logic [127:0]        victim_data;
    logic                miss_ack;
    logic                busy;

    // controller -> cache refill
    logic                fill_valid;
    logic [127:0]        fill_data;
    logic [TAG_W-1:0]    fill_tag;
    logic [1:0]          fill_index;
    logic                fill_ack;

    // controller <-> memory
    logic                mem_req;
    logic                mem_we;
    logic [c_ADDR_W-1:0] mem_addr;
    logic [31:0]         mem_wdata;
    logic [31:0]         mem_rdata;
    logic                mem_ack;

    modport master (
        input  miss_req, miss_tag, miss_index, victim_dirty, victim_tag,
               victim_data, fill_ack, mem_rdata, mem_ack,
        output miss_ack, busy, fill_valid, fill_data, fill_tag, fill_index,
               mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output miss_req, miss_tag, miss_index, victim_dirty, victim_tag,
               victim_data, fill_ack, mem_rdata, mem_ack,
        input  miss_ack, busy, fill_valid, fill_data, fill_tag, fill_index,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cache_refill_ctrl
//  Description : Cache miss handler. Writes back a dirty victim line as four
//                32-bit beats, fetches the missing line as four beats and
//                presents the assembled 128-bit line to the cache.
//  Revision    : 1.0 - initial release
// ============================================================================
module cache_refill_ctrl #(
    parameter int TAG_W = 26,
    parameter int BEATS = 4
) (
    input  logic                clk,
    input  logic                reset,
    cache_refill_ctrl_if.master bus
);
    localparam int c_LINE_W = BEATS * 32;
    localparam int c_ADDR_W = TAG_W + 6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2,
        FILL      = 2'd3
    } state_t;

    state_t                r_state,        w_state_nxt;
    logic [1:0]            r_beat,         w_beat_nxt;
    logic [TAG_W-1:0]      r_miss_tag,     w_miss_tag_nxt;
    logic [1:0]            r_miss_index,   w_miss_index_nxt;
    logic [TAG_W-1:0]      r_victim_tag,   w_victim_tag_nxt;
    logic [c_LINE_W-1:0]   r_victim_data,  w_victim_data_nxt;
    logic [c_LINE_W-1:0]   r_line,         w_line_nxt;
    logic                  r_miss_ack,     w_miss_ack_nxt;
    logic                  r_mem_req,      w_mem_req_nxt;
    logic                  r_mem_we,       w_mem_we_nxt;
    logic [c_ADDR_W-1:0]   r_mem_addr,     w_mem_addr_nxt;
    logic [31:0]           r_mem_wdata,    w_mem_wdata_nxt;
    logic                  r_fill_valid,   w_fill_valid_nxt;
    logic                  w_beat_done;

    // A beat only completes while we are actually requesting; stray acks are dropped
    assign w_beat_done = r_mem_req & bus.mem_ack;

    // Next-state, capture and line assembly; outputs are precomputed from the next state
    always_comb begin
        w_state_nxt       = r_state;
        w_beat_nxt        = r_beat;
        w_miss_tag_nxt    = r_miss_tag;
        w_miss_index_nxt  = r_miss_index;
        w_victim_tag_nxt  = r_victim_tag;
        w_victim_data_nxt = r_victim_data;
        w_line_nxt        = r_line;
        w_miss_ack_nxt    = 1'b0;
        w_mem_req_nxt     = 1'b0;
        w_mem_we_nxt      = 1'b0;
        w_mem_addr_nxt    = '0;
        w_mem_wdata_nxt   = '0;
        w_fill_valid_nxt  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (bus.miss_req) begin
                    w_miss_ack_nxt    = 1'b1;
                    w_miss_tag_nxt    = bus.miss_tag;
                    w_miss_index_nxt  = bus.miss_index;
                    w_victim_tag_nxt  = bus.victim_tag;
                    w_victim_data_nxt = bus.victim_data;
                    w_beat_nxt        = 2'd0;
                    w_state_nxt       = bus.victim_dirty ? WRITEBACK : FETCH;
                end
            end
            WRITEBACK: begin
                if (w_beat_done) begin
                    w_beat_nxt = r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        w_state_nxt = FETCH;
                    end
                end
            end
            FETCH: begin
                if (w_beat_done) begin
                    w_line_nxt[{r_beat, 5'd0} +: 32] = bus.mem_rdata;
                    w_beat_nxt = r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        w_state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                if (bus.fill_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // Memory beat for the upcoming cycle; address/data move only after an ack edge
        if (w_state_nxt == WRITEBACK) begin
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = 1'b1;
            w_mem_addr_nxt  = {w_victim_tag_nxt, w_miss_index_nxt, w_beat_nxt, 2'b00};
            w_mem_wdata_nxt = w_victim_data_nxt[{w_beat_nxt, 5'd0} +: 32];
        end else if (w_state_nxt == FETCH) begin
            w_mem_req_nxt   = 1'b1;
            w_mem_addr_nxt  = {w_miss_tag_nxt, w_miss_index_nxt, w_beat_nxt, 2'b00};
        end
        w_fill_valid_nxt = (w_state_nxt == FILL);
    end

    // State, captured request and registered outputs; active-low synchronous clear
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_beat        <= 2'd0;
            r_miss_tag    <= '0;
            r_miss_index  <= '0;
            r_victim_tag  <= '0;
            r_victim_data <= '0;
            r_line        <= '0;
            r_miss_ack    <= 1'b0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_fill_valid  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_beat        <= w_beat_nxt;
            r_miss_tag    <= w_miss_tag_nxt;
            r_miss_index  <= w_miss_index_nxt;
            r_victim_tag  <= w_victim_tag_nxt;
            r_victim_data <= w_victim_data_nxt;
            r_line        <= w_line_nxt;
            r_miss_ack    <= w_miss_ack_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_fill_valid  <= w_fill_valid_nxt;
        end
    end

    assign bus.miss_ack   = r_miss_ack;
    assign bus.busy       = (r_state != IDLE);
    assign bus.fill_valid = r_fill_valid;
    assign bus.fill_data  = r_line;
    assign bus.fill_tag   = r_miss_tag;
    assign bus.fill_index = r_miss_index;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
endmodule
`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cache_refill_ctrl
//  Description : Directed self-checking bench for cache_refill_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_refill_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   t0;
    logic [127:0] exp_line;

    cache_refill_ctrl_if #(.TAG_W(26)) bus ();

    cache_refill_ctrl #(.TAG_W(26), .BEATS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, " miss_ack"},   128'(bus.miss_ack),   128'd0);
        check({tag, " busy"},       128'(bus.busy),       128'd0);
        check({tag, " fill_valid"}, 128'(bus.fill_valid), 128'd0);
        check({tag, " mem_req"},    128'(bus.mem_req),    128'd0);
        check({tag, " mem_we"},     128'(bus.mem_we),     128'd0);
        check({tag, " mem_addr"},   128'(bus.mem_addr),   128'd0);
        check({tag, " mem_wdata"},  128'(bus.mem_wdata),  128'd0);
        check({tag, " fill_data"},  bus.fill_data,        128'd0);
        check({tag, " fill_tag"},   128'(bus.fill_tag),   128'd0);
        check({tag, " fill_index"}, 128'(bus.fill_index), 128'd0);
    endtask

    // One memory beat: hold off the ack for 'waits' cycles, then ack it
    task automatic mem_beat(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] rdata, input int waits);
        bus.mem_ack = 1'b0;
        for (int w = 0; w < waits; w++) begin
            check({tag, " req(wait)"},  128'(bus.mem_req),  128'd1);
            check({tag, " addr(wait)"}, 128'(bus.mem_addr), 128'(addr));
            if (we) check({tag, " wdata(wait)"}, 128'(bus.mem_wdata), 128'(wdata));
            tick();
        end
        check({tag, " req"},  128'(bus.mem_req),  128'd1);
        check({tag, " we"},   128'(bus.mem_we),   128'(we));
        check({tag, " addr"}, 128'(bus.mem_addr), 128'(addr));
        if (we) check({tag, " wdata"}, 128'(bus.mem_wdata), 128'(wdata));
        check({tag, " no fill yet"}, 128'(bus.fill_valid), 128'd0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'd0;
    endtask

    task automatic request(input logic [25:0] tag, input logic [1:0] idx, input logic dirty,
                           input logic [25:0] vtag, input logic [127:0] vdata);
        bus.miss_req     = 1'b1;
        bus.miss_tag     = tag;
        bus.miss_index   = idx;
        bus.victim_dirty = dirty;
        bus.victim_tag   = vtag;
        bus.victim_data  = vdata;
        t0 = cyc;
        tick();
        check("ack pulse", 128'(bus.miss_ack), 128'd1);
        check("busy",      128'(bus.busy),     128'd1);
        // scramble request inputs: only the captured copies may be used
        bus.miss_req     = 1'b0;
        bus.miss_tag     = 26'h3FFFFFF;
        bus.miss_index   = 2'd3;
        bus.victim_dirty = 1'b0;
        bus.victim_tag   = 26'h2AAAAAA;
        bus.victim_data  = {4{32'hDEADBEEF}};
    endtask

    task automatic release_fill(input string tag);
        bus.fill_ack = 1'b1;
        tick();
        bus.fill_ack = 1'b0;
        check({tag, " idle busy"},       128'(bus.busy),       128'd0);
        check({tag, " idle fill_valid"}, 128'(bus.fill_valid), 128'd0);
        check({tag, " idle mem_req"},    128'(bus.mem_req),    128'd0);
    endtask

    initial begin
        reset            = 1'b0;
        bus.miss_req     = 1'b0;
        bus.miss_tag     = '0;
        bus.miss_index   = '0;
        bus.victim_dirty = 1'b0;
        bus.victim_tag   = '0;
        bus.victim_data  = '0;
        bus.fill_ack     = 1'b0;
        bus.mem_rdata    = '0;
        bus.mem_ack      = 1'b0;

        // ---- reset state
        tick();
        tick();
        check_idle_zero("reset");
        reset = 1'b1;
        tick();

        // ---- clean miss, zero-wait memory
        request(26'd256, 2'd1, 1'b0, 26'd0, 128'd0);
        mem_beat("clean b0", 1'b0, 32'h4010, 32'h0, 32'hFFFFFFFF, 0);
        check("ack one cycle", 128'(bus.miss_ack), 128'd0);
        mem_beat("clean b1", 1'b0, 32'h4014, 32'h0, 32'hFFFFFFFF, 0);
        mem_beat("clean b2", 1'b0, 32'h4018, 32'h0, 32'hFFFFFFFF, 0);
        mem_beat("clean b3", 1'b0, 32'h401C, 32'h0, 32'hFFFFFFFF, 0);
        check("clean fill_valid", 128'(bus.fill_valid), 128'd1);
        check("clean latency",    128'(cyc - t0),       128'd5);
        check("clean fill_data",  bus.fill_data,        {128{1'b1}});
        check("clean fill_tag",   128'(bus.fill_tag),   128'd256);
        check("clean fill_index", 128'(bus.fill_index), 128'd1);
        check("clean no mem_req", 128'(bus.mem_req),    128'd0);
        release_fill("clean");

        // ---- dirty victim writeback then fetch, with fill backpressure
        request(26'd257, 2'd2, 1'b1, 26'd117, 128'h61626364626364656364656664656667);
        mem_beat("wb b0", 1'b1, 32'h1D60, 32'h64656667, 32'h0, 0);
        mem_beat("wb b1", 1'b1, 32'h1D64, 32'h63646566, 32'h0, 0);
        mem_beat("wb b2", 1'b1, 32'h1D68, 32'h62636465, 32'h0, 0);
        mem_beat("wb b3", 1'b1, 32'h1D6C, 32'h61626364, 32'h0, 0);
        mem_beat("dfetch b0", 1'b0, 32'h4060, 32'h0, 32'hA0000000, 0);
        mem_beat("dfetch b1", 1'b0, 32'h4064, 32'h0, 32'hA0000001, 0);
        mem_beat("dfetch b2", 1'b0, 32'h4068, 32'h0, 32'hA0000002, 0);
        mem_beat("dfetch b3", 1'b0, 32'h406C, 32'h0, 32'hA0000003, 0);
        check("dirty latency", 128'(cyc - t0), 128'd9);
        exp_line = {32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000};
        for (int i = 0; i < 4; i++) begin
            bus.miss_req = (i == 1 || i == 2);
            check("bp fill_valid", 128'(bus.fill_valid), 128'd1);
            check("bp fill_data",  bus.fill_data,        exp_line);
            check("bp fill_tag",   128'(bus.fill_tag),   128'd257);
            check("bp fill_index", 128'(bus.fill_index), 128'd2);
            check("bp no ack",     128'(bus.miss_ack),   128'd0);
            check("bp no mem_req", 128'(bus.mem_req),    128'd0);
            tick();
        end
        bus.miss_req = 1'b0;
        check("bp after pulses no ack", 128'(bus.miss_ack), 128'd0);
        release_fill("bp");

        // ---- stray mem_ack in IDLE
        bus.mem_ack = 1'b1;
        tick();
        tick();
        bus.mem_ack = 1'b0;
        check("stray mem_ack busy",    128'(bus.busy),     128'd0);
        check("stray mem_ack mem_req", 128'(bus.mem_req),  128'd0);
        check("stray mem_ack no ack",  128'(bus.miss_ack), 128'd0);

        // ---- wait states (2 per beat), stray fill_ack during FETCH
        request(26'd3, 2'd0, 1'b0, 26'd0, 128'd0);
        bus.fill_ack = 1'b1;
        mem_beat("wait b0", 1'b0, 32'h00C0, 32'h0, 32'h0BAD0000, 2);
        bus.fill_ack = 1'b0;
        check("stray fill_ack busy", 128'(bus.busy), 128'd1);
        mem_beat("wait b1", 1'b0, 32'h00C4, 32'h0, 32'h0BAD0001, 2);
        mem_beat("wait b2", 1'b0, 32'h00C8, 32'h0, 32'h0BAD0002, 2);
        mem_beat("wait b3", 1'b0, 32'h00CC, 32'h0, 32'h0BAD0003, 2);
        check("wait fill_valid", 128'(bus.fill_valid), 128'd1);
        check("wait latency",    128'(cyc - t0),       128'd13);
        exp_line = {32'h0BAD0003, 32'h0BAD0002, 32'h0BAD0001, 32'h0BAD0000};
        check("wait fill_data",  bus.fill_data,        exp_line);
        check("wait fill_tag",   128'(bus.fill_tag),   128'd3);
        release_fill("wait");

        // ---- reset during FETCH beat 2
        request(26'd5, 2'd3, 1'b0, 26'd0, 128'd0);
        mem_beat("rst b0", 1'b0, 32'h0170, 32'h0, 32'h11111111, 0);
        mem_beat("rst b1", 1'b0, 32'h0174, 32'h0, 32'h22222222, 0);
        check("rst b2 addr", 128'(bus.mem_addr), 128'h178);
        reset = 1'b0;
        tick();
        check_idle_zero("midreset");
        reset = 1'b1;
        tick();
        tick();
        check("post reset fill_valid", 128'(bus.fill_valid), 128'd0);
        check("post reset busy",       128'(bus.busy),       128'd0);

        // ---- clean miss after reset completes normally
        request(26'd6, 2'd0, 1'b0, 26'd0, 128'd0);
        mem_beat("after b0", 1'b0, 32'h0180, 32'h0, 32'h01234567, 0);
        mem_beat("after b1", 1'b0, 32'h0184, 32'h0, 32'h89ABCDEF, 0);
        mem_beat("after b2", 1'b0, 32'h0188, 32'h0, 32'h5A5A5A5A, 0);
        mem_beat("after b3", 1'b0, 32'h018C, 32'h0, 32'hC3C3C3C3, 0);
        check("after latency",    128'(cyc - t0),       128'd5);
        check("after fill_valid", 128'(bus.fill_valid), 128'd1);
        check("after fill_data",  bus.fill_data,
              {32'hC3C3C3C3, 32'h5A5A5A5A, 32'h89ABCDEF, 32'h01234567});
        check("after fill_tag",   128'(bus.fill_tag),   128'd6);
        check("after fill_index", 128'(bus.fill_index), 128'd0);
        release_fill("after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/cache_refill_ctrl.md
# cache_refill_ctrl

Miss handler that sits directly downstream of `cache_8way`, between the cache and a 32-bit word-wide main memory port. On a cache miss it first writes back the victim line if that line is dirty. It then fetches the missing 16-byte line as four 32-bit beats and hands the assembled 128-bit line to the cache as its refill `dataIn`. One miss is serviced at a time.

## Interface
Parameters
- `TAG_W`, 26, tag width; address = {tag, index[1:0], offset[3:0]}, so 32 bits total
- `BEATS`, 4, 32-bit words per line; fixed, not otherwise configurable

Ports
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-low; state is cleared on a `clk` edge while `reset`=0
- `miss_req`  in  1  cache reports a miss; held until `miss_ack`
- `miss_tag`  in  26  tag of the missing line
- `miss_index`  in  2  set index of the missing line
- `victim_dirty`  in  1  victim way holds modified data
- `victim_tag`  in  26  tag of the victim line
- `victim_data`  in  128  victim line; byte k = bits [8k+7:8k]
- `miss_ack`  out  1  one-cycle pulse; request captured
- `busy`  out  1  a miss is in progress (any state except IDLE)
- `fill_valid`  out  1  refill line is available; held until `fill_ack`
- `fill_data`  out  128  assembled line; word w = bits [32w+31:32w]
- `fill_tag`  out  26  captured `miss_tag`
- `fill_index`  out  2  captured `miss_index`
- `fill_ack`  in  1  cache has written the line
- `mem_req`  out  1  memory beat request
- `mem_we`  out  1  1 = write beat, 0 = read beat
- `mem_addr`  out  32  byte address, word aligned ([1:0] = 0)
- `mem_wdata`  out  32  write data
- `mem_rdata`  in  32  read data; valid when `mem_ack`=1
- `mem_ack`  in  1  beat completes on the edge where `mem_req`&`mem_ack`=1

## Operation
- States: IDLE, WRITEBACK, FETCH, FILL. A 2-bit beat counter `beat` is used in WRITEBACK and FETCH.
- **IDLE**
  - If `miss_req`=1: pulse `miss_ack` that cycle.
  - Capture `miss_tag`, `miss_index`, `victim_dirty`, `victim_tag`, `victim_data`.
  - Clear `beat`.
  - Next state is WRITEBACK if `victim_dirty`=1, otherwise FETCH.
- **WRITEBACK**
  - Drive `mem_req`=1 and `mem_we`=1.
  - `mem_addr` = {victim_tag, index, beat, 2'b00}.
  - `mem_wdata` = victim word `beat`.
  - On `mem_ack`: increment `beat`. After beat 3, wrap `beat` to 0 and go to FETCH.
- **FETCH**
  - Drive `mem_req`=1 and `mem_we`=0.
  - `mem_addr` = {miss_tag, index, beat, 2'b00}.
  - On `mem_ack`: store `mem_rdata` into word `beat` of the line buffer and increment `beat`. After beat 3, go to FILL.
- **FILL**
  - `fill_valid`=1; `fill_data`, `fill_tag` and `fill_index` are held stable.
  - On `fill_ack`=1: go to IDLE.
- `busy` = (state != IDLE).
- `mem_req` stays high across consecutive beats; address and data change only after the edge on which `mem_ack` was sampled.
- Ignored inputs:
  - `miss_req` outside IDLE: `miss_ack` stays 0 and nothing is captured.
  - `mem_ack` while `mem_req`=0.
  - `fill_ack` while `fill_valid`=0.
- `victim_data` and the request fields are used only from the captured copies. Input changes after `miss_ack` have no effect.

## Timing
- Reset values (applied while `reset`=0 at a `clk` edge):
  - state = IDLE, `beat` = 0.
  - `miss_ack`, `busy`, `fill_valid`, `mem_req`, `mem_we` = 0.
  - `mem_addr`, `mem_wdata`, `fill_data`, `fill_tag`, `fill_index` = 0.
  - Line buffer and captured fields cleared.
- Reset mid-operation: the transaction is abandoned in the same edge and outputs take their reset values the next cycle. No partial fill is ever presented.
- `miss_ack` and `mem_*`, `fill_*` outputs are registered, driven from state.
- `mem_ack` may be asserted in the first cycle `mem_req` is high (zero-wait memory).
- Minimum latency from `miss_req` sampled to `fill_valid`=1, zero-wait memory:
  - Clean victim: 1 (IDLE) + 4 (FETCH) = 5 cycles.
  - Dirty victim: 1 + 4 (WRITEBACK) + 4 (FETCH) = 9 cycles.
- Each memory wait cycle adds 1 to this latency.
- From `fill_ack` sampled: IDLE on the next cycle, and a new `miss_req` can be acked that same cycle.

## Test plan
- **Clean read miss, zero-wait memory.** `miss_tag`=256, `miss_index`=1, `victim_dirty`=0.
  - Expect `miss_ack` 1 cycle, then reads at 0x4010, 0x4014, 0x4018, 0x401C.
  - Memory returns 0xFFFFFFFF each beat; expect `fill_data`=128'hFF…FF, `fill_tag`=256, `fill_index`=1, `fill_valid` 5 cycles after the request.
- **Dirty victim, then fetch.** `victim_tag`=117, `miss_index`=2, `victim_data`=128'h61626364626364656364656664656667, `miss_tag`=257.
  - Expect writes to 0x1D60/64/68/6C with data 0x64656667, 0x63646566, 0x62636465, 0x61626364.
  - Then reads from 0x4060..0x406C.
- **Memory wait states.** Delay `mem_ack` by 2 cycles per beat.
  - Expect `mem_addr`/`mem_wdata` stable while waiting and `fill_valid` at 5+8=13 cycles for a clean miss.
- **Fill backpressure.** Hold `fill_ack`=0 for 4 cycles and pulse `miss_req` meanwhile.
  - Expect `fill_*` stable, no `miss_ack`, and IDLE the cycle after `fill_ack`.
- **Reset mid-operation.** Drive `reset`=0 during FETCH beat 2.
  - Expect all outputs 0 next cycle and no `fill_valid`.
  - A following clean miss completes normally.
- **Stray handshakes.** Drive `mem_ack`=1 in IDLE and `fill_ack`=1 in FETCH.
  - Expect no state change and the beat counter unaffected.
